sram_sp_gf180_tiled: RTL and testbench

- Parametrised single-port SRAM built from tiles of gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper macros.
- Tiled in width (8-bit byte lanes) and depth (512-row banks).
- Adds per-byte write enables, a valid/ready request handshake and a registered read response.
- Includes an optional power-up clear sequencer.
- Serves as the generic backing store for caches, TLBs and tag arrays in the SoC.

---
 rtl/sram_sp_gf180_tiled.sv | 204 ++++++++++++++++++++
 tb/tb_sram_sp_gf180_tiled.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sram_sp_gf180_tiled.sv
// Single-port SRAM tiled from 512x8 GF180 macros (byte lanes x 512-row banks),
// with byte enables, valid/ready requests, registered read response and power-up clear.
//   state  | meaning
//   S_INIT | array being cleared (or one idle cycle when INIT_CLEAR=0); requests held off
//   S_RUN  | array usable; every request accepted
module sram_sp_gf180_tiled #(
  parameter int DATA_W     = 56,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH),
  parameter int INIT_CLEAR = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                 VDD,
  inout  wire                 VSS,
`endif
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [AW-1:0]       req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done
);

  localparam int NLANES = DATA_W / 8;
  localparam int NBANKS = DEPTH / 512;
  localparam int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1;

  if (DATA_W % 8 != 0) begin : g_chk_w
    $error("sram_sp_gf180_tiled: DATA_W must be a multiple of 8");
  end
  if (DEPTH % 512 != 0) begin : g_chk_d
    $error("sram_sp_gf180_tiled: DEPTH must be a multiple of 512");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [BW-1:0] rsp_bank_q, rsp_bank_d;
  logic        rsp_oor_q, rsp_oor_d;

  logic [BW-1:0]     req_bank;
  logic              in_range;
  logic              accept;
  logic              clr_active;
  logic [NBANKS-1:0] bank_cen_n;
  logic              mac_gwen;
  logic [DATA_W-1:0] mac_wen;
  logic [8:0]        mac_a;
  logic [DATA_W-1:0] mac_d;
  logic [NBANKS-1:0][DATA_W-1:0] q_bank;

  if (NBANKS > 1) begin : g_bank_sel
    assign req_bank = req_addr[AW-1:9];
  end else begin : g_bank_zero
    assign req_bank = '0;
  end

  // Bank codes past NBANKS exist only when NBANKS is not a power of two.
  assign in_range = (32'(req_bank) < NBANKS);
  assign accept   = req_valid && (state_q == S_RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_active = 1'b0;
    case (state_q)
      S_INIT: begin
        if (INIT_CLEAR != 0) begin
          clr_active = 1'b1;
          cnt_d      = cnt_q + 9'd1;
          if (cnt_q == 9'd511) state_d = S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign req_ready = (state_q == S_RUN);
  assign init_done = (state_q == S_RUN);

  always_comb begin
    bank_cen_n = '1;
    mac_gwen   = 1'b1;
    mac_wen    = '1;
    mac_a      = req_addr[8:0];
    mac_d      = req_wdata;
    if (!reset) begin
      if (clr_active) begin
        // All banks clear the same row in parallel.
        bank_cen_n = '0;
        mac_gwen   = 1'b0;
        mac_wen    = '0;
        mac_a      = cnt_q;
        mac_d      = '0;
      end else if (accept && in_range) begin
        for (int b = 0; b < NBANKS; b++) begin
          if (req_bank == BW'(b)) bank_cen_n[b] = 1'b0;
        end
        if (req_we) begin
          mac_gwen = 1'b0;
          for (int i = 0; i < NLANES; i++) begin
            mac_wen[8*i +: 8] = req_be[i] ? 8'h00 : 8'hFF;
          end
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = accept && !req_we;
    rsp_bank_d  = rsp_bank_q;
    rsp_oor_d   = rsp_oor_q;
    if (accept && !req_we) begin
      rsp_bank_d = req_bank;
      rsp_oor_d  = !in_range;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
      rsp_oor_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bank_q  <= rsp_bank_d;
      rsp_oor_q   <= rsp_oor_d;
    end
  end

  assign rsp_valid = rsp_valid_q;

  always_comb begin
    rsp_rdata = '0;
    if (!rsp_oor_q) begin
      for (int b = 0; b < NBANKS; b++) begin
        if (rsp_bank_q == BW'(b)) rsp_rdata = q_bank[b];
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
      gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper u_mac (
`ifdef USE_POWER_PINS
        .VDD  (VDD),
        .VSS  (VSS),
`endif
        .CLK  (clk),
        .CEN  (bank_cen_n[b]),
        .GWEN (mac_gwen),
        .WEN  (mac_wen[8*l +: 8]),
        .A    (mac_a),
        .D    (mac_d[8*l +: 8]),
        .Q    (q_bank[b][8*l +: 8])
      );
    end
  end

endmodule

`ifndef GF180MCU_SRAM_MACRO
// Behavioural stand-in for the 512x8 macro; the real library cell replaces it when defined.
module gf180mcu_fd_ip_sram__sram512x8m8wm1_wrapper (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);
  logic [7:0] mem [512];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int i = 0; i < 8; i++) begin
          if (!WEN[i]) mem[A][i] <= D[i];
        end
      end else begin
        Q <= mem[A];
      end
    end
  end
endmodule
`endif

// File: tb/tb_sram_sp_gf180_tiled.sv
// Scoreboard bench: two instances (56x1024 with clear, 32x1536 without clear).
module tb_sram_sp_gf180_tiled;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [6:0]  a_req_be;
  logic [9:0]  a_req_addr;
  logic [55:0] a_req_wdata, a_rsp_rdata;
  logic        a_rsp_valid, a_init_done;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [3:0]  b_req_be;
  logic [10:0] b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic        b_rsp_valid, b_init_done;

  sram_sp_gf180_tiled dut_a (
    .clk(clk), .reset(rst_a),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_be(a_req_be), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .init_done(a_init_done)
  );

  sram_sp_gf180_tiled #(.DATA_W(32), .DEPTH(1536), .INIT_CLEAR(0)) dut_b (
    .clk(clk), .reset(rst_b),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_be(b_req_be), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .init_done(b_init_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [55:0] qa[$];
  logic [31:0] qb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_rsp_valid) begin
      if (qa.size() == 0) check("a_unexpected_rsp", 64'(a_rsp_valid), 64'(0));
      else check("a_rdata", 64'(a_rsp_rdata), 64'(qa.pop_front()));
    end
    if (b_rsp_valid) begin
      if (qb.size() == 0) check("b_unexpected_rsp", 64'(b_rsp_valid), 64'(0));
      else check("b_rdata", 64'(b_rsp_rdata), 64'(qb.pop_front()));
    end
  end

  // Issue one request on instance sel; reads push their expected data when accepted.
  task automatic req(input bit sel, input bit we, input logic [6:0] be,
                     input logic [10:0] addr, input logic [55:0] wd, input logic [55:0] exp);
    int n;
    @(negedge clk);
    if (!sel) begin
      a_req_valid = 1'b1; a_req_we = we; a_req_be = be;
      a_req_addr = addr[9:0]; a_req_wdata = wd;
    end else begin
      b_req_valid = 1'b1; b_req_we = we; b_req_be = be[3:0];
      b_req_addr = addr; b_req_wdata = wd[31:0];
    end
    n = 0;
    while (!(sel ? b_req_ready : a_req_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("req_accept_timeout", 64'(n), 64'(0));
    else if (!we) begin
      if (!sel) qa.push_back(exp);
      else qb.push_back(exp[31:0]);
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic wait_init(input bit sel, output int n);
    n = 0;
    while (!(sel ? b_init_done : a_init_done) && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = '1; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_be = '0; b_req_addr = '0; b_req_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 64'(a_req_ready), 64'(0));
    check("reset_rsp_valid", 64'(a_rsp_valid), 64'(0));
    check("reset_init_done", 64'(a_init_done), 64'(0));
    check("reset_cen_high", 64'(dut_a.bank_cen_n), 64'(2'b11));
    a_req_valid = 1'b0;

    rst_a = 1'b0;
    wait_init(1'b0, n);
    check("clear_cycles", 64'(n), 64'(512));

    req(0, 0, 7'h00, 11'h000, 56'h0, 56'h0);
    req(0, 0, 7'h00, 11'h1FF, 56'h0, 56'h0);
    req(0, 0, 7'h00, 11'h200, 56'h0, 56'h0);
    req(0, 0, 7'h00, 11'h3FF, 56'h0, 56'h0);

    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_be = 7'h7F;
    a_req_addr = 10'h005; a_req_wdata = 56'h11223344556677;
    #1 check("bank_sel_cen", 64'(dut_a.bank_cen_n), 64'(2'b10));
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    req(0, 1, 7'h7F, 11'h205, 56'hAABBCCDDEEFF00, 56'h0);
    req(0, 0, 7'h00, 11'h005, 56'h0, 56'h11223344556677);
    req(0, 0, 7'h00, 11'h205, 56'h0, 56'hAABBCCDDEEFF00);

    req(0, 1, 7'h7F,       11'h010, 56'hFFFFFFFFFFFFFF, 56'h0);
    req(0, 1, 7'b0000101,  11'h010, 56'h0, 56'h0);
    req(0, 0, 7'h00,       11'h010, 56'h0, 56'hFFFFFFFF00FF00);

    req(0, 1, 7'h00, 11'h205, 56'h0, 56'h0);
    req(0, 0, 7'h00, 11'h205, 56'h0, 56'hAABBCCDDEEFF00);

    req(0, 1, 7'h7F, 11'h005, 56'h123, 56'h0);
    req(0, 0, 7'h00, 11'h005, 56'h0, 56'h123);
    req(0, 0, 7'h00, 11'h205, 56'h0, 56'hAABBCCDDEEFF00);
    @(negedge clk);
    check("pipelined_second_valid", 64'(a_rsp_valid), 64'(1));
    repeat (3) @(negedge clk);

    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (200) @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("midclr_rsp_valid", 64'(a_rsp_valid), 64'(0));
    check("midclr_init_done", 64'(a_init_done), 64'(0));
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_be = '0; a_req_addr = 10'h005;
    wait_init(1'b0, n);
    check("reclear_cycles", 64'(n), 64'(512));
    if (n < 2000) qa.push_back(56'h0);
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    repeat (3) @(negedge clk);

    rst_b = 1'b0;
    wait_init(1'b1, n);
    check("noclear_cycles", 64'(n), 64'(1));
    req(1, 1, 7'h0F, 11'h5FF, 56'hDEADBEEF, 56'h0);
    req(1, 0, 7'h00, 11'h5FF, 56'h0, 56'hDEADBEEF);
    req(1, 1, 7'h0F, 11'h005, 56'h0BADF00D, 56'h0);
    req(1, 1, 7'h0F, 11'h605, 56'h11111111, 56'h0);
    req(1, 0, 7'h00, 11'h005, 56'h0, 56'h0BADF00D);
    req(1, 0, 7'h00, 11'h600, 56'h0, 56'h0);

    repeat (4) @(negedge clk);
    check("a_queue_drained", 64'(qa.size()), 64'(0));
    check("b_queue_drained", 64'(qb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
